// File: rtl/wb_queue_stage.sv
// Write-back queue stage: buffers completed results in a DEPTH-entry FIFO,
// drains them to the register-file write port and forwards queued values.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             discard queued and incoming results
//   in_valid/in_ready upstream handshake; in_wen, in_rd, in_data result
//   rf_valid/rf_ready register-file handshake; rf_waddr, rf_wdata head entry
//   fwd_addr          bypass lookup; fwd_hit, fwd_data newest match
//   count             queued entries; stall = in_valid && !in_ready
module wb_queue_stage #(
   parameter int N_BITS    = 32,
   parameter int RF_ADDR_W = 5,
   parameter int DEPTH     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_wen,
   input  logic [RF_ADDR_W-1:0]       in_rd,
   input  logic [N_BITS-1:0]          in_data,
   output logic                       rf_valid,
   input  logic                       rf_ready,
   output logic [RF_ADDR_W-1:0]       rf_waddr,
   output logic [N_BITS-1:0]          rf_wdata,
   input  logic [RF_ADDR_W-1:0]       fwd_addr,
   output logic                       fwd_hit,
   output logic [N_BITS-1:0]          fwd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       stall
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [N_BITS-1:0]    data_q [DEPTH];
   logic [RF_ADDR_W-1:0] rd_q   [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic push, enq, pop;
   int   slot;

   // Pointer wrap works for non power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Ready depends on registered occupancy only.
   assign in_ready = (count_q < CW'(DEPTH));
   assign rf_valid = (count_q != '0);
   assign stall    = in_valid && !in_ready;
   assign count    = count_q;

   assign rf_waddr = rf_valid ? rd_q[rptr_q]   : '0;
   assign rf_wdata = rf_valid ? data_q[rptr_q] : '0;

   // Accepted results with no destination are consumed without an entry.
   assign push = in_valid && in_ready && !flush;
   assign enq  = push && in_wen && (in_rd != '0);
   assign pop  = rf_valid && rf_ready && !flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            wptr_d = ptr_inc(wptr_q);
         end
         if (pop) begin
            rptr_d = ptr_inc(rptr_q);
         end
         unique case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (rst_n && enq) begin
         data_q[wptr_q] <= in_data;
         rd_q[wptr_q]   <= in_rd;
      end
   end

   // Walk oldest to newest so the last match is the newest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = 0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = int'(rptr_q) + k;
         if (slot >= DEPTH) begin
            slot = slot - DEPTH;
         end
         if ((k < int'(count_q)) && (fwd_addr != '0) &&
             (rd_q[slot[PW-1:0]] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[slot[PW-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Bench for wb_queue_stage: directed vector table plus a
// scoreboard-checked random phase.
module tb_wb_queue_stage;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, in_wen;
   logic [4:0]    in_rd;
   logic [31:0]   in_data;
   logic          rf_valid, rf_ready;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [4:0]    fwd_addr;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [CW-1:0] count;
   logic          stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_queue_stage #(
      .N_BITS(32), .RF_ADDR_W(5), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_rd(in_rd), .in_data(in_data),
      .rf_valid(rf_valid), .rf_ready(rf_ready),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .count(count), .stall(stall)
   );

   typedef struct {
      logic        rst_n, flush, in_valid, in_wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        rf_ready;
      logic [4:0]  fa;
      int          e_cnt;
      logic        e_rdy, e_rfv;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_hit;
      logic [31:0] e_fd;
      logic        e_stall;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   vec_t vt[$];
   ent_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, f, v, w, input logic [4:0] rd,
                      input logic [31:0] d, input logic rr,
                      input logic [4:0] fa, input int c,
                      input logic rdy, rfv, input logic [4:0] wa,
                      input logic [31:0] wd, input logic h,
                      input logic [31:0] fd, input logic st);
      vec_t x;
      x.rst_n = r; x.flush = f; x.in_valid = v; x.in_wen = w;
      x.rd = rd; x.data = d; x.rf_ready = rr; x.fa = fa;
      x.e_cnt = c; x.e_rdy = rdy; x.e_rfv = rfv;
      x.e_wa = wa; x.e_wd = wd; x.e_hit = h; x.e_fd = fd;
      x.e_stall = st;
      vt.push_back(x);
   endtask

   initial begin
      ent_t        e;
      logic        full, exp_hit;
      logic [31:0] exp_fd;

      rst_n = 0; flush = 0; in_valid = 0; in_wen = 0;
      in_rd = 0; in_data = 0; rf_ready = 0; fwd_addr = 0;
      @(posedge clk); #1;

      //  rst f  v  w  rd  data          rr fa cnt rdy rfv wa wd            h  fd            st
      add(0, 0, 1, 1, 5, 32'h99,        0, 5, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 1, 5, 32'hDEADBEEF,  0, 5, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 0, 1, 5, 32'h0,         0, 5, 1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
      add(1, 0, 0, 1, 5, 32'h0,         1, 5, 1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
      add(1, 0, 1, 1, 3, 32'h11,        0, 3, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 1, 3, 32'h22,        0, 3, 1, 1, 1, 3, 32'h11,       1, 32'h11,       0);
      add(1, 0, 1, 1, 7, 32'h33,        0, 3, 2, 0, 1, 3, 32'h11,       1, 32'h22,       1);
      add(1, 0, 1, 1, 7, 32'h33,        1, 3, 2, 0, 1, 3, 32'h11,       1, 32'h22,       1);
      add(1, 0, 1, 1, 7, 32'h33,        0, 7, 1, 1, 1, 3, 32'h22,       0, 0,            0);
      add(1, 0, 0, 1, 7, 32'h0,         1, 7, 2, 0, 1, 3, 32'h22,       1, 32'h33,       0);
      add(1, 0, 0, 1, 7, 32'h0,         1, 3, 1, 1, 1, 7, 32'h33,       0, 0,            0);
      add(1, 0, 1, 1, 0, 32'h44,        0, 0, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 0, 9, 32'h55,        0, 0, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 0, 0, 9, 32'h0,         0, 9, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 1, 1, 32'hA1,        0, 1, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 1, 2, 32'hA2,        0, 1, 1, 1, 1, 1, 32'hA1,       1, 32'hA1,       0);
      add(1, 1, 1, 1, 4, 32'hA4,        1, 2, 2, 0, 1, 1, 32'hA1,       1, 32'hA2,       1);
      add(1, 0, 0, 1, 4, 32'h0,         0, 2, 0, 1, 0, 0, 0,            0, 0,            0);
      add(1, 0, 1, 1, 6, 32'hB6,        0, 6, 0, 1, 0, 0, 0,            0, 0,            0);
      add(0, 0, 1, 1, 6, 32'hB7,        1, 6, 1, 1, 1, 6, 32'hB6,       1, 32'hB6,       0);
      add(1, 0, 0, 1, 6, 32'h0,         0, 6, 0, 1, 0, 0, 0,            0, 0,            0);

      for (int i = 0; i < vt.size(); i++) begin
         rst_n = vt[i].rst_n; flush = vt[i].flush;
         in_valid = vt[i].in_valid; in_wen = vt[i].in_wen;
         in_rd = vt[i].rd; in_data = vt[i].data;
         rf_ready = vt[i].rf_ready; fwd_addr = vt[i].fa;
         #1;
         chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].e_cnt));
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d rf_valid", i), 32'(rf_valid), 32'(vt[i].e_rfv));
         chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vt[i].e_wa));
         chk($sformatf("v%0d rf_wdata", i), rf_wdata, vt[i].e_wd);
         chk($sformatf("v%0d fwd_hit", i), 32'(fwd_hit), 32'(vt[i].e_hit));
         chk($sformatf("v%0d fwd_data", i), fwd_data, vt[i].e_fd);
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(vt[i].e_stall));
         @(posedge clk); #1;
      end

      // Random traffic against a scoreboard; queue is empty here.
      rst_n = 1;
      for (int c = 0; c < 400; c++) begin
         flush    = ($urandom_range(0, 19) == 0);
         in_valid = $urandom_range(0, 1) == 1;
         in_wen   = $urandom_range(0, 5) != 0;
         in_rd    = 5'($urandom_range(0, 7));
         in_data  = $urandom;
         rf_ready = $urandom_range(0, 2) == 0;
         fwd_addr = 5'($urandom_range(0, 7));
         #1;
         full    = (sb.size() >= DEPTH);
         exp_hit = 1'b0;
         exp_fd  = '0;
         for (int k = 0; k < sb.size(); k++) begin
            if (fwd_addr != 0 && sb[k].rd == fwd_addr) begin
               exp_hit = 1'b1;
               exp_fd  = sb[k].d;
            end
         end
         chk("rnd count", 32'(count), 32'(sb.size()));
         chk("rnd in_ready", 32'(in_ready), 32'(!full));
         chk("rnd rf_valid", 32'(rf_valid), 32'(sb.size() != 0));
         chk("rnd stall", 32'(stall), 32'(in_valid && full));
         chk("rnd fwd_hit", 32'(fwd_hit), 32'(exp_hit));
         chk("rnd fwd_data", fwd_data, exp_fd);
         if (flush) begin
            sb.delete();
         end else begin
            if (rf_ready && sb.size() != 0) begin
               e = sb.pop_front();
               chk("rnd rf_waddr", 32'(rf_waddr), 32'(e.rd));
               chk("rnd rf_wdata", rf_wdata, e.d);
            end
            if (in_valid && !full && in_wen && in_rd != 0) begin
               e.rd = in_rd;
               e.d  = in_data;
               sb.push_back(e);
            end
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
